core_issue_ctrl: RTL

Backend-side consumer of the front end's two-slot instruction handshake. It decides each cycle how many of the presented instructions (0, 1 or 2, in order) are accepted, and returns that count on the issue mask. It enforces register hazards against a long-latency scoreboard, intra-pair dependencies and structural limits. Accepted instructions go into a registered execute-entry pipeline stage.

---
 rtl/core_issue_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/core_issue_ctrl.sv
// Two-wide in-order issue control: scoreboard hazards, pair rules, ex-entry stage.
// Package carries the front-end bundle shared with the fetch side.
package core_issue_pkg;

  typedef struct packed {
    logic long_latency;
    logic mem_op;
    logic single_issue;
  } decode_info_t;

  typedef struct packed {
    logic [1:0][4:0] r_reg;
    logic [4:0]      w_reg;
  } reg_info_t;

  typedef struct packed {
    decode_info_t decode_info;
    reg_info_t    reg_info;
    logic [31:0]  pc;
    logic         bpu_predict;
    logic         fetch_excp;
  } inst_t;

  typedef struct packed {
    logic [1:0]      inst_valid;
    inst_t [1:0]     inst;
  } frontend_req_t;

endpackage

module core_issue_ctrl
  import core_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  frontend_req_t   frontend_req_i,
  output logic [1:0]      issue_o,
  input  logic            rst_jmp_i,
  input  logic            ex_ready_i,
  output logic [1:0]      ex_valid_o,
  output inst_t [1:0]     ex_inst_o,
  input  logic [1:0]      rel_valid_i,
  input  logic [1:0][4:0] rel_reg_i,
  output logic            busy_o
);

  logic [31:0]  busy_q;
  logic [31:0]  busy_d;
  logic [1:0]   ex_valid_q;
  logic [1:0]   ex_valid_d;
  inst_t [1:0]  ex_inst_q;
  inst_t [1:0]  ex_inst_d;

  logic [31:0]  rel_mask;
  logic [31:0]  eff_busy;
  logic         ld;
  logic         s0_go;
  logic         s1_go;
  logic         s0_drain_ok;
  logic         pair_raw;
  logic         pair_waw;
  logic         pair_mem;
  logic         pair_single;

  inst_t i0;
  inst_t i1;

  assign i0 = frontend_req_i.inst[0];
  assign i1 = frontend_req_i.inst[1];

  function automatic logic sb_free(
    input inst_t       in,
    input logic [31:0] eb
  );
    logic ok;
    ok = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (in.reg_info.r_reg[r] != 5'd0 &&
          eb[in.reg_info.r_reg[r]])
        ok = 1'b0;
    end
    if (in.reg_info.w_reg != 5'd0 &&
        eb[in.reg_info.w_reg])
      ok = 1'b0;
    return ok;
  endfunction

  always_comb begin
    rel_mask = '0;
    for (int k = 0; k < 2; k++) begin
      if (rel_valid_i[k])
        rel_mask[rel_reg_i[k]] = 1'b1;
    end
    rel_mask[0] = 1'b0;
  end

  // Release bypass: a register freed this cycle no longer blocks issue.
  assign eff_busy = busy_q & ~rel_mask;

  assign ld = ex_ready_i | (ex_valid_q == 2'b00);

  assign s0_drain_ok = !i0.decode_info.single_issue ||
                       (busy_q == '0 && ex_valid_q == 2'b00);

  assign s0_go = rst_n &&
                 ld &&
                 frontend_req_i.inst_valid[0] &&
                 !rst_jmp_i &&
                 sb_free(i0, eff_busy) &&
                 s0_drain_ok;

  assign pair_raw =
    i0.reg_info.w_reg != 5'd0 &&
    (i1.reg_info.r_reg[0] == i0.reg_info.w_reg ||
     i1.reg_info.r_reg[1] == i0.reg_info.w_reg);

  assign pair_waw =
    i0.reg_info.w_reg != 5'd0 &&
    i1.reg_info.w_reg == i0.reg_info.w_reg;

  assign pair_mem = i0.decode_info.mem_op &
                    i1.decode_info.mem_op;

  assign pair_single = i0.decode_info.single_issue |
                       i1.decode_info.single_issue;

  assign s1_go = s0_go &&
                 frontend_req_i.inst_valid[1] &&
                 !pair_single &&
                 sb_free(i1, eff_busy) &&
                 !pair_raw &&
                 !pair_waw &&
                 !pair_mem;

  assign issue_o = {s1_go, s0_go};

  always_comb begin
    busy_d = busy_q & ~rel_mask;
    // Killed ops never reach writeback, so their claim is dropped here.
    if (rst_jmp_i && !ex_ready_i) begin
      for (int s = 0; s < 2; s++) begin
        if (ex_valid_q[s] &&
            ex_inst_q[s].decode_info.long_latency &&
            ex_inst_q[s].reg_info.w_reg != 5'd0)
          busy_d[ex_inst_q[s].reg_info.w_reg] = 1'b0;
      end
    end
    if (s0_go && i0.decode_info.long_latency &&
        i0.reg_info.w_reg != 5'd0)
      busy_d[i0.reg_info.w_reg] = 1'b1;
    if (s1_go && i1.decode_info.long_latency &&
        i1.reg_info.w_reg != 5'd0)
      busy_d[i1.reg_info.w_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_inst_d  = ex_inst_q;
    unique case (1'b1)
      rst_jmp_i: begin
        ex_valid_d = 2'b00;
      end
      (!rst_jmp_i && ld): begin
        ex_valid_d = issue_o;
        ex_inst_d  = frontend_req_i.inst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      ex_valid_q <= 2'b00;
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    ex_inst_q <= ex_inst_d;
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_inst_o  = ex_inst_q;
  assign busy_o     = |busy_q;

endmodule
